// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: memory geometry defaults, the
// data returned on a faulting load, and the MEM/WB pipeline register layout.
package mem_stage_pkg;

    localparam int unsigned MEM_WORDS_DEFAULT = 64;
    localparam int unsigned AW_DEFAULT        = 6;

    localparam logic [31:0] ADDR_ERR_DATA = 32'h0000_0000;

    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic [4:0]  writereg;
        logic [31:0] readdata;
        logic [31:0] aluout;
        logic        addrerr;
    } memwb_t;

endpackage

// File: rtl/mem_stage_dmem.sv
// Word-addressed data memory: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset.
module dmem
    import mem_stage_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter int unsigned AW        = AW_DEFAULT
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [MEM_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read sees the pre-edge contents; a same-edge write lands afterwards.
    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: address decode, data memory access, MEM/WB register
// and the writeback result mux (ResultW doubles as a forwarding source).
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter int unsigned AW        = AW_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [4:0]  WriteRegM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [4:0]  WriteRegW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [31:0] ResultW,
    output logic        AddrErrW
);

    logic [AW-1:0] word_idx;
    logic          addr_valid;
    logic          mem_we;
    logic [31:0]   mem_rdata;
    logic [31:0]   read_data_m;
    memwb_t        memwb_d;
    memwb_t        memwb_q;

    assign word_idx   = ALUOutM[AW+1:2];
    assign addr_valid = (ALUOutM[1:0] == 2'b00) && (~|ALUOutM[31:AW+2]);

    // Gating on reset keeps a store presented during reset out of memory.
    assign mem_we = MemWriteM & addr_valid & ~reset;

    dmem #(
        .MEM_WORDS(MEM_WORDS),
        .AW       (AW)
    ) u_dmem (
        .clk_i  (clk),
        .we_i   (mem_we),
        .addr_i (word_idx),
        .wdata_i(WriteDataM),
        .rdata_o(mem_rdata)
    );

    assign read_data_m = addr_valid ? mem_rdata : ADDR_ERR_DATA;

    always_comb begin
        memwb_d          = '0;
        memwb_d.regwrite = RegWriteM & ~(MemtoRegM & ~addr_valid);
        memwb_d.memtoreg = MemtoRegM;
        memwb_d.writereg = WriteRegM;
        memwb_d.readdata = read_data_m;
        memwb_d.aluout   = ALUOutM;
        memwb_d.addrerr  = (MemWriteM | MemtoRegM) & ~addr_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memwb_q <= '0;
        end else begin
            memwb_q <= memwb_d;
        end
    end

    assign RegWriteW = memwb_q.regwrite;
    assign MemtoRegW = memwb_q.memtoreg;
    assign WriteRegW = memwb_q.writereg;
    assign ReadDataW = memwb_q.readdata;
    assign ALUOutW   = memwb_q.aluout;
    assign AddrErrW  = memwb_q.addrerr;
    assign ResultW   = memwb_q.memtoreg ? memwb_q.readdata : memwb_q.aluout;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stores, loads, ALU pass-through, address
// faults and asynchronous reset, each checked with an immediate assertion.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        RegWriteM;
    logic        MemtoRegM;
    logic        MemWriteM;
    logic [4:0]  WriteRegM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic        RegWriteW;
    logic        MemtoRegW;
    logic [4:0]  WriteRegW;
    logic [31:0] ReadDataW;
    logic [31:0] ALUOutW;
    logic [31:0] ResultW;
    logic        AddrErrW;

    int checks = 0;
    int errors = 0;

    mem_stage #(
        .MEM_WORDS(64),
        .AW       (6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .RegWriteM (RegWriteM),
        .MemtoRegM (MemtoRegM),
        .MemWriteM (MemWriteM),
        .WriteRegM (WriteRegM),
        .ALUOutM   (ALUOutM),
        .WriteDataM(WriteDataM),
        .RegWriteW (RegWriteW),
        .MemtoRegW (MemtoRegW),
        .WriteRegW (WriteRegW),
        .ReadDataW (ReadDataW),
        .ALUOutW   (ALUOutW),
        .ResultW   (ResultW),
        .AddrErrW  (AddrErrW)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic rw, input logic m2r, input logic mw,
                         input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] wd);
        RegWriteM  = rw;
        MemtoRegM  = m2r;
        MemWriteM  = mw;
        WriteRegM  = wr;
        ALUOutM    = alu;
        WriteDataM = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_regwrite"}, 32'(RegWriteW), 32'h0);
        check({tag, "_memtoreg"}, 32'(MemtoRegW), 32'h0);
        check({tag, "_writereg"}, 32'(WriteRegW), 32'h0);
        check({tag, "_readdata"}, ReadDataW, 32'h0);
        check({tag, "_aluout"},   ALUOutW,   32'h0);
        check({tag, "_result"},   ResultW,   32'h0);
        check({tag, "_addrerr"},  32'(AddrErrW), 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 5'd7, 32'h0000_ABCD, 32'h0);
        step();
        check_all_zero("reset");

        // Store 0xDEADBEEF to 0x10, then load it back to r5
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_0010, 32'hDEAD_BEEF);
        step();
        check("st10_addrerr", 32'(AddrErrW), 32'h0);
        check("st10_regwrite", 32'(RegWriteW), 32'h0);

        drive(1'b1, 1'b1, 1'b0, 5'd5, 32'h0000_0010, 32'h0);
        step();
        check("ld10_readdata", ReadDataW, 32'hDEAD_BEEF);
        check("ld10_result", ResultW, 32'hDEAD_BEEF);
        check("ld10_writereg", 32'(WriteRegW), 32'd5);
        check("ld10_regwrite", 32'(RegWriteW), 32'h1);
        check("ld10_memtoreg", 32'(MemtoRegW), 32'h1);
        check("ld10_addrerr", 32'(AddrErrW), 32'h0);

        // ALU result passes through
        drive(1'b1, 1'b0, 1'b0, 5'd9, 32'h0000_1234, 32'h0);
        step();
        check("alu_result", ResultW, 32'h0000_1234);
        check("alu_aluout", ALUOutW, 32'h0000_1234);
        check("alu_writereg", 32'(WriteRegW), 32'd9);
        check("alu_addrerr", 32'(AddrErrW), 32'h0);
        check("alu_memtoreg", 32'(MemtoRegW), 32'h0);

        // Non-memory op with a wild address value never flags an error
        drive(1'b1, 1'b0, 1'b0, 5'd10, 32'hFFFF_FFFF, 32'h0);
        step();
        check("nomem_addrerr", 32'(AddrErrW), 32'h0);
        check("nomem_regwrite", 32'(RegWriteW), 32'h1);
        check("nomem_result", ResultW, 32'hFFFF_FFFF);

        // Misaligned store to 0x12 aliases word 4 but must not write
        drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_0012, 32'h0000_0055);
        step();
        check("st12_addrerr", 32'(AddrErrW), 32'h1);

        drive(1'b1, 1'b1, 1'b0, 5'd6, 32'h0000_0010, 32'h0);
        step();
        check("ld10_after_bad_st", ReadDataW, 32'hDEAD_BEEF);
        check("ld10_after_bad_st_err", 32'(AddrErrW), 32'h0);

        // Back-to-back stores to 0x0, then load
        drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_0000, 32'h0000_0001);
        step();
        drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_0000, 32'h0000_0002);
        step();
        drive(1'b1, 1'b1, 1'b0, 5'd4, 32'h0000_0000, 32'h0);
        step();
        check("ld0_b2b", ReadDataW, 32'h0000_0002);
        check("ld0_b2b_result", ResultW, 32'h0000_0002);

        // Out-of-range load from 0x100 aliases word 0 but must read zero
        drive(1'b1, 1'b1, 1'b0, 5'd3, 32'h0000_0100, 32'h0);
        step();
        check("ld100_readdata", ReadDataW, 32'h0);
        check("ld100_result", ResultW, 32'h0);
        check("ld100_regwrite", 32'(RegWriteW), 32'h0);
        check("ld100_addrerr", 32'(AddrErrW), 32'h1);

        // Out-of-range store must not alias into word 0
        drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_0100, 32'h0000_0077);
        step();
        check("st100_addrerr", 32'(AddrErrW), 32'h1);
        drive(1'b1, 1'b1, 1'b0, 5'd4, 32'h0000_0000, 32'h0);
        step();
        check("ld0_after_st100", ReadDataW, 32'h0000_0002);

        // Misaligned load
        drive(1'b1, 1'b1, 1'b0, 5'd8, 32'h0000_0011, 32'h0);
        step();
        check("ld11_readdata", ReadDataW, 32'h0);
        check("ld11_regwrite", 32'(RegWriteW), 32'h0);
        check("ld11_addrerr", 32'(AddrErrW), 32'h1);

        // Mid-cycle reset clears outputs at once and blocks a store
        drive(1'b1, 1'b0, 1'b0, 5'd12, 32'h0000_00AA, 32'h0);
        step();
        check("pre_rst_regwrite", 32'(RegWriteW), 32'h1);
        #2;
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 5'd13, 32'h0000_0010, 32'h0000_0BAD);
        #1;
        check_all_zero("async_rst");
        step();
        check_all_zero("held_rst");

        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 5'd14, 32'h0000_0010, 32'h0);
        step();
        check("ld10_after_rst", ReadDataW, 32'hDEAD_BEEF);
        check("ld10_after_rst_wr", 32'(WriteRegW), 32'd14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 64, meaning the number of 32-bit words of data memory (power of two, 16..1024).
REQ-002 The block SHALL have parameter AW, default 6, meaning the word-index width, equal to log2(MEM_WORDS).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have ports RegWriteM, MemtoRegM, MemWriteM, each input, 1 bit: control from the EX/MEM register.
REQ-006 The block SHALL have port WriteRegM, input, 5 bits: destination register of the instruction in MEM.
REQ-007 The block SHALL have ports ALUOutM and WriteDataM, each input, 32 bits: byte address or ALU result, and store data.
REQ-008 The block SHALL have ports RegWriteW and MemtoRegW, each output, 1 bit: registered control for writeback.
REQ-009 The block SHALL have port WriteRegW, output, 5 bits: registered destination register.
REQ-010 The block SHALL have ports ReadDataW and ALUOutW, each output, 32 bits: registered load data and ALU result.
REQ-011 The block SHALL have port ResultW, output, 32 bits: combinational writeback value, also used as a forwarding source.
REQ-012 The block SHALL have port AddrErrW, output, 1 bit: registered flag marking a misaligned or out-of-range access.

Function
REQ-013 Word index SHALL be ALUOutM[AW+1:2]; access valid SHALL mean ALUOutM[1:0]==0 and ALUOutM[31:AW+2]==0.
REQ-014 A store SHALL write WriteDataM to the indexed word on the rising clk edge when MemWriteM=1, access valid and reset=0.
REQ-015 A store with an invalid access SHALL leave memory unchanged.
REQ-016 Read data SHALL be combinational from the current index, returning the word's contents before any write on the same edge.
REQ-017 A load issued the cycle after a store to the same word SHALL return the newly stored data.
REQ-018 An invalid load SHALL read as 32'h0000_0000.
REQ-019 On each rising edge, the MEM/WB register SHALL capture RegWriteM, MemtoRegM, WriteRegM, ALUOutM and read data; latency SHALL be 1 cycle.
REQ-020 AddrErrW SHALL capture (MemWriteM|MemtoRegM) & ~valid.
REQ-021 When a load is invalid (MemtoRegM=1, access invalid), RegWriteW SHALL be captured as 0 so the register file is not written.
REQ-022 ResultW SHALL equal ReadDataW when MemtoRegW=1, else ALUOutW.
REQ-023 Non-memory instructions (MemWriteM=0, MemtoRegM=0) SHALL never raise AddrErrW, regardless of ALUOutM value.

Reset
REQ-024 While reset=1, all MEM/WB outputs SHALL be 0 (RegWriteW, MemtoRegW, WriteRegW, ReadDataW, ALUOutW, AddrErrW), and hence ResultW=0.
REQ-025 Reset asserted mid-operation SHALL clear outputs immediately without waiting for clk, and SHALL suppress any store on that edge.
REQ-026 Memory contents SHALL NOT be reset; software/bench SHALL initialise before reading.

Structure
REQ-027 A shared package SHALL hold the MEM_WORDS/AW defaults and the constant ADDR_ERR_DATA = 32'h0.
REQ-028 Data memory SHALL be a separate sub-module dmem, with one synchronous write port and one asynchronous read port; mem_stage SHALL hold the decode, the MEM/WB register and the result mux.

Verification
REQ-029 Store ALUOutM=0x10, WriteDataM=0xDEADBEEF, MemWriteM=1; next cycle load 0x10 with MemtoRegM=1, RegWriteM=1, WriteRegM=5 -> one cycle later ReadDataW=0xDEADBEEF, ResultW=0xDEADBEEF, WriteRegW=5, RegWriteW=1.
REQ-030 ALU op ALUOutM=0x1234, RegWriteM=1, MemtoRegM=0, WriteRegM=9 -> next cycle ResultW=0x1234, WriteRegW=9, AddrErrW=0.
REQ-031 Store to 0x12 (misaligned) with data 0x55 -> AddrErrW=1 next cycle; a subsequent load from 0x10 returns the prior contents, not 0x55.
REQ-032 Load from 0x100 with MEM_WORDS=64 (out of range), RegWriteM=1 -> ReadDataW=0, RegWriteW=0, AddrErrW=1.
REQ-033 Assert reset between clock edges while RegWriteW=1 -> all outputs 0 immediately; a store presented during reset leaves memory unchanged.
REQ-034 Back-to-back stores to 0x0 (0x1, then 0x2), then a load from 0x0 -> ReadDataW=0x2.
